// File: rtl/split_route_ctrl.sv
// Credit-based route controller in front of a 1:2 split: it holds one packet, picks the output from a destination bit, and sends when that output has a credit.
// Optional per-output handshake counters (pkt_cnt0/pkt_cnt1) are enabled with `define SPLIT_ROUTE_CTRL_STATS_EN.
module split_route_ctrl #(
  parameter int WIDTH   = 11,
  parameter int ADDR_W  = 3,
  parameter int LEVEL   = 0,
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic [1:0]       cred_ret,
  output logic             busy,
  output logic             err_ovf
`ifdef SPLIT_ROUTE_CTRL_STATS_EN
  ,
  output logic [15:0]      pkt_cnt0,
  output logic [15:0]      pkt_cnt1
`endif
);

  localparam int         SEL_IDX  = WIDTH - ADDR_W + LEVEL;
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DECIDE      = 2'd1,
    WAIT_CREDIT = 2'd2,
    SEND        = 2'd3
  } state_e;

  // Next credit value plus overflow flag; a return and a send on the same counter cancel out.
  function automatic logic [4:0] cred_next(input logic [3:0] cnt, input logic ret,
                                           input logic dec, input logic [3:0] max_cnt);
    logic [4:0] res;
    res = {1'b0, cnt};
    if (ret && !dec) begin
      if (cnt == max_cnt) begin
        res = {1'b1, cnt};
      end else begin
        res = {1'b0, cnt + 4'd1};
      end
    end else if (dec && !ret) begin
      res = {1'b0, cnt - 4'd1};
    end else begin
      res = {1'b0, cnt};
    end
    return res;
  endfunction

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;
  logic             busy_q;
  logic             err_ovf_q;
  logic [3:0]       credit0_q;
  logic [3:0]       credit1_q;
  logic [3:0]       credit0_d;
  logic [3:0]       credit1_d;
  logic             ovf0_s;
  logic             ovf1_s;
  logic             send_fire_s;
  logic             dec0_s;
  logic             dec1_s;
  logic             sel_d_s;
  logic             decide_ok_s;
  logic             wait_ok_s;

  assign send_fire_s = out_valid_q & out_ready;
  assign dec0_s      = send_fire_s & ~sel_q;
  assign dec1_s      = send_fire_s & sel_q;
  assign sel_d_s     = data_q[SEL_IDX];

  assign {ovf0_s, credit0_d} = cred_next(credit0_q, cred_ret[0], dec0_s, CRED_MAX);
  assign {ovf1_s, credit1_d} = cred_next(credit1_q, cred_ret[1], dec1_s, CRED_MAX);

  // DECIDE looks at the settled counter; WAIT_CREDIT also sees a return arriving this cycle.
  assign decide_ok_s = sel_d_s ? (credit1_q != 4'd0) : (credit0_q != 4'd0);
  assign wait_ok_s   = sel_q   ? (credit1_d != 4'd0) : (credit0_d != 4'd0);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign busy      = busy_q;
  assign err_ovf   = err_ovf_q;

  // Packet-handling FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= in_data;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= DECIDE;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        DECIDE: begin
          sel_q <= sel_d_s;
          if (decide_ok_s) begin
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end else begin
            state_q <= WAIT_CREDIT;
          end
        end
        WAIT_CREDIT: begin
          if (wait_ok_s) begin
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end else begin
            state_q <= WAIT_CREDIT;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= SEND;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Credit counters and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit0_q <= CRED_MAX;
      credit1_q <= CRED_MAX;
      err_ovf_q <= 1'b0;
    end else begin
      credit0_q <= credit0_d;
      credit1_q <= credit1_d;
      err_ovf_q <= err_ovf_q | ovf0_s | ovf1_s;
    end
  end

`ifdef SPLIT_ROUTE_CTRL_STATS_EN
  logic [15:0] pkt_cnt0_q;
  logic [15:0] pkt_cnt1_q;

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

  // Completed output handshakes per select value, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0_q <= 16'd0;
      pkt_cnt1_q <= 16'd0;
    end else begin
      if (dec0_s) begin
        pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
      end else begin
        pkt_cnt0_q <= pkt_cnt0_q;
      end
      if (dec1_s) begin
        pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
      end else begin
        pkt_cnt1_q <= pkt_cnt1_q;
      end
    end
  end
`endif

endmodule
